// File: rtl/debug_pkg.sv
// Shared types and limits for the register-file debug scanner.
package debug_pkg;

   localparam int unsigned READ_LAT_MAX = 7;
   localparam int unsigned WAIT_W       = $clog2(READ_LAT_MAX + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, PRESENT, DONE} scan_state_t;

   typedef logic [1:0] scan_mode_t;
   localparam scan_mode_t MODE_SINGLE     = 2'd0;
   localparam scan_mode_t MODE_SWEEP      = 2'd1;
   localparam scan_mode_t MODE_CONTINUOUS = 2'd2;

endpackage

// File: rtl/debug_regfile_scan.sv
// Walks an address range of the CPU debug register-file port and streams
// one {addr, data} beat per register over a valid/ready interface.
module debug_regfile_scan
   import debug_pkg::*;
#(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned READ_LAT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   input  logic              stop,
   output logic              busy,
   output logic [ADDR_W-1:0] debug_regfile_addr,
   input  logic [DATA_W-1:0] debug_regfile_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              done,
   output logic              aborted
);

   if (READ_LAT > READ_LAT_MAX) begin : g_lat_check
      $error("debug_regfile_scan: READ_LAT exceeds READ_LAT_MAX");
   end

   scan_state_t       state_q, state_d;
   scan_mode_t        mode_q, mode_d;
   logic [ADDR_W-1:0] first_q, first_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic [ADDR_W-1:0] dbg_addr_q, dbg_addr_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              prime_q, prime_d;
   logic              stop_pending_q, stop_pending_d;
   logic              busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;
   logic              aborted_q, aborted_d;

   // Next-state and next-output computation
   always_comb begin
      state_d        = state_q;
      mode_d         = mode_q;
      first_d        = first_q;
      last_d         = last_q;
      dbg_addr_d     = dbg_addr_q;
      wait_d         = wait_q;
      prime_d        = prime_q;
      stop_pending_d = stop_pending_q;
      out_valid_d    = out_valid_q;
      out_addr_d     = out_addr_q;
      out_data_d     = out_data_q;
      out_last_d     = out_last_q;
      done_d         = 1'b0;
      aborted_d      = 1'b0;

      case (state_q)
         IDLE: begin
            stop_pending_d = 1'b0;
            if (start) begin
               mode_d  = (mode == MODE_SINGLE || mode == MODE_CONTINUOUS) ? mode : MODE_SWEEP;
               first_d = first_addr;
               last_d  = last_addr;
               prime_d = 1'b1;
               wait_d  = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (stop) stop_pending_d = 1'b1;
            // The first cycle after start only drives the address out to the port.
            if (prime_q) begin
               prime_d    = 1'b0;
               dbg_addr_d = first_q;
               wait_d     = '0;
            end else if (wait_q == WAIT_W'(READ_LAT)) begin
               out_data_d  = debug_regfile_data;
               out_addr_d  = dbg_addr_q;
               out_last_d  = (mode_q == MODE_SINGLE) || (dbg_addr_q == last_q);
               out_valid_d = 1'b1;
               state_d     = PRESENT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         PRESENT: begin
            if (stop) stop_pending_d = 1'b1;
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               wait_d      = '0;
               if (stop_pending_q) begin
                  state_d        = DONE;
                  done_d         = 1'b1;
                  aborted_d      = 1'b1;
                  stop_pending_d = 1'b0;
               end else if (mode_q == MODE_SINGLE || (out_last_q && mode_q != MODE_CONTINUOUS)) begin
                  state_d        = DONE;
                  done_d         = 1'b1;
                  stop_pending_d = 1'b0;
               end else if (out_last_q) begin
                  dbg_addr_d = first_q;
                  state_d    = ISSUE;
               end else begin
                  dbg_addr_d = dbg_addr_q + ADDR_W'(1);
                  state_d    = ISSUE;
               end
            end
         end
         DONE: begin
            stop_pending_d = 1'b0;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         mode_q         <= MODE_SINGLE;
         first_q        <= '0;
         last_q         <= '0;
         dbg_addr_q     <= '0;
         wait_q         <= '0;
         prime_q        <= 1'b0;
         stop_pending_q <= 1'b0;
         busy_q         <= 1'b0;
         out_valid_q    <= 1'b0;
         out_addr_q     <= '0;
         out_data_q     <= '0;
         out_last_q     <= 1'b0;
         done_q         <= 1'b0;
         aborted_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         mode_q         <= mode_d;
         first_q        <= first_d;
         last_q         <= last_d;
         dbg_addr_q     <= dbg_addr_d;
         wait_q         <= wait_d;
         prime_q        <= prime_d;
         stop_pending_q <= stop_pending_d;
         busy_q         <= busy_d;
         out_valid_q    <= out_valid_d;
         out_addr_q     <= out_addr_d;
         out_data_q     <= out_data_d;
         out_last_q     <= out_last_d;
         done_q         <= done_d;
         aborted_q      <= aborted_d;
      end
   end

   assign busy               = busy_q;
   assign debug_regfile_addr = dbg_addr_q;
   assign out_valid          = out_valid_q;
   assign out_addr           = out_addr_q;
   assign out_data           = out_data_q;
   assign out_last           = out_last_q;
   assign done               = done_q;
   assign aborted            = aborted_q;

endmodule

// File: tb/tb_debug_regfile_scan.sv
// Scoreboard bench for debug_regfile_scan: one instance at READ_LAT=0, one at READ_LAT=3.
module tb_debug_regfile_scan;
   import debug_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset = 1'b1;
   logic              start0 = 1'b0, start3 = 1'b0, stop = 1'b0;
   logic [1:0]        mode = 2'd0;
   logic [ADDR_W-1:0] first_addr = '0, last_addr = '0;
   logic              out_ready = 1'b0;

   logic              busy0, valid0, last0, done0, aborted0;
   logic [ADDR_W-1:0] dbg_addr0, oaddr0;
   logic [DATA_W-1:0] dbg_data0, odata0;
   logic              busy3, valid3, last3, done3, aborted3;
   logic [ADDR_W-1:0] dbg_addr3, oaddr3;
   logic [DATA_W-1:0] dbg_data3, odata3;

   debug_regfile_scan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .mode(mode),
      .first_addr(first_addr), .last_addr(last_addr), .stop(stop), .busy(busy0),
      .debug_regfile_addr(dbg_addr0), .debug_regfile_data(dbg_data0),
      .out_valid(valid0), .out_ready(out_ready), .out_addr(oaddr0), .out_data(odata0),
      .out_last(last0), .done(done0), .aborted(aborted0));

   debug_regfile_scan #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .mode(mode),
      .first_addr(first_addr), .last_addr(last_addr), .stop(stop), .busy(busy3),
      .debug_regfile_addr(dbg_addr3), .debug_regfile_data(dbg_data3),
      .out_valid(valid3), .out_ready(out_ready), .out_addr(oaddr3), .out_data(odata3),
      .out_last(last3), .done(done3), .aborted(aborted3));

   // Register-file models: zero latency r[i]=i*4; three-cycle latency r[i]=0xA0000000|i
   assign dbg_data0 = 32'(dbg_addr0) << 2;
   logic [ADDR_W-1:0] pipe3_a = '0, pipe3_b = '0, pipe3_c = '0;
   always @(posedge clk) begin
      pipe3_a <= dbg_addr3;
      pipe3_b <= pipe3_a;
      pipe3_c <= pipe3_b;
   end
   assign dbg_data3 = 32'hA000_0000 | 32'(pipe3_c);

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   beat_t q0[$], q3[$];
   logic  dq0[$], dq3[$];
   int    last_hs = -1;
   logic  gap_chk = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic push0(input logic [ADDR_W-1:0] a, input logic l);
      beat_t b;
      b.addr = a;
      b.data = 32'(a) << 2;
      b.last = l;
      q0.push_back(b);
   endtask

   // Monitor: pops expected beats/done events as the DUTs present them
   logic  hold_v = 1'b0;
   beat_t hold_b;
   always @(negedge clk) begin
      beat_t e;
      if (reset) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v) begin
            check("hold_valid", 64'(valid0), 64'd1);
            check("hold_addr", 64'(oaddr0), 64'(hold_b.addr));
            check("hold_data", 64'(odata0), 64'(hold_b.data));
            check("hold_last", 64'(last0), 64'(hold_b.last));
         end
         hold_v = 1'b0;
         if (valid0 && out_ready) begin
            if (q0.size() == 0) begin
               check("unexpected_beat0", 64'(oaddr0), 64'hFFFF);
            end else begin
               e = q0.pop_front();
               check("beat0_addr", 64'(oaddr0), 64'(e.addr));
               check("beat0_data", 64'(odata0), 64'(e.data));
               check("beat0_last", 64'(last0), 64'(e.last));
            end
            if (gap_chk && last_hs >= 0) check("beat0_gap", 64'(cyc - last_hs), 64'd2);
            last_hs = cyc;
         end else if (valid0) begin
            hold_v = 1'b1;
            hold_b.addr = oaddr0;
            hold_b.data = odata0;
            hold_b.last = last0;
         end
         if (done0) begin
            check("done0_busy", 64'(busy0), 64'd1);
            if (dq0.size() == 0) check("unexpected_done0", 64'd1, 64'd0);
            else check("done0_aborted", 64'(aborted0), 64'(dq0.pop_front()));
         end
         if (valid3 && out_ready) begin
            if (q3.size() == 0) begin
               check("unexpected_beat3", 64'(oaddr3), 64'hFFFF);
            end else begin
               e = q3.pop_front();
               check("beat3_addr", 64'(oaddr3), 64'(e.addr));
               check("beat3_data", 64'(odata3), 64'(e.data));
               check("beat3_last", 64'(last3), 64'(e.last));
            end
         end
         if (done3) begin
            if (dq3.size() == 0) check("unexpected_done3", 64'd1, 64'd0);
            else check("done3_aborted", 64'(aborted3), 64'(dq3.pop_front()));
         end
      end
   end

   task automatic cmd0(input logic [1:0] m, input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
      @(posedge clk); #1;
      start0 = 1'b1; mode = m; first_addr = f; last_addr = l;
      @(posedge clk); #1;
      start0 = 1'b0;
   endtask

   task automatic wait_done0(input string nm, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done0) seen = 1'b1;
      end
      if (!seen) check({nm, "_timeout"}, 64'd0, 64'd1);
      @(negedge clk);
      check({nm, "_busy_fall"}, 64'(busy0), 64'd0);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_busy"}, 64'(busy0), 64'd0);
      check({nm, "_valid"}, 64'(valid0), 64'd0);
      check({nm, "_last"}, 64'(last0), 64'd0);
      check({nm, "_done"}, 64'(done0), 64'd0);
      check({nm, "_aborted"}, 64'(aborted0), 64'd0);
      check({nm, "_dbg_addr"}, 64'(dbg_addr0), 64'd0);
      check({nm, "_out_addr"}, 64'(oaddr0), 64'd0);
      check({nm, "_out_data"}, 64'(odata0), 64'd0);
      check({nm, "_busy3"}, 64'(busy3), 64'd0);
      check({nm, "_valid3"}, 64'(valid3), 64'd0);
   endtask

   initial begin
      beat_t b;
      int    k;
      int    seen3;
      logic [11:0] rdy_pat;
      logic [ADDR_W-1:0] prev_dbg;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // Full sweep 0..31, ready high, beats every second cycle
      out_ready = 1'b1;
      for (int i = 0; i < 32; i++) push0(ADDR_W'(i), i == 31);
      dq0.push_back(1'b0);
      last_hs = -1;
      gap_chk = 1'b1;
      cmd0(MODE_SWEEP, 5'd0, 5'd31);
      wait_done0("sweep", 200);
      gap_chk = 1'b0;

      // Single read at READ_LAT=3: out_valid 5 edges after the accepting edge
      b.addr = 5'd5; b.data = 32'hA000_0005; b.last = 1'b1;
      q3.push_back(b);
      dq3.push_back(1'b0);
      @(posedge clk); #1;
      start3 = 1'b1; mode = MODE_SINGLE; first_addr = 5'd5; last_addr = 5'd9;
      @(posedge clk); #1;
      start3 = 1'b0;
      k = 0;
      while (!valid3 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("single3_latency", 64'(k), 64'd5);
      repeat (4) @(posedge clk);

      // Wrap through the top of the space, reserved mode behaves as sweep
      push0(5'd30, 1'b0); push0(5'd31, 1'b0); push0(5'd0, 1'b0); push0(5'd1, 1'b1);
      dq0.push_back(1'b0);
      last_hs = -1;
      gap_chk = 1'b1;
      cmd0(2'd3, 5'd30, 5'd1);
      wait_done0("wrap", 50);
      gap_chk = 1'b0;

      // Backpressure with an ignored start while busy
      for (int i = 8; i <= 15; i++) push0(ADDR_W'(i), i == 15);
      dq0.push_back(1'b0);
      rdy_pat = 12'b1011_0010_1101;
      cmd0(MODE_SWEEP, 5'd8, 5'd15);
      fork
         begin
            for (int i = 0; i < 12; i++) begin
               out_ready = rdy_pat[i];
               @(posedge clk); #1;
            end
            out_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            repeat (3) @(posedge clk);
            #1 start0 = 1'b1; mode = MODE_SINGLE; first_addr = 5'd20; last_addr = 5'd20;
            @(posedge clk); #1 start0 = 1'b0;
         end
      join
      wait_done0("bp", 200);
      repeat (5) @(negedge clk);
      check("bp_no_restart", 64'(busy0), 64'd0);
      out_ready = 1'b1;

      // Continuous 2..4, stop while the second-pass read of addr 3 is issued
      push0(5'd2, 1'b0); push0(5'd3, 1'b0); push0(5'd4, 1'b1);
      push0(5'd2, 1'b0); push0(5'd3, 1'b0);
      dq0.push_back(1'b1);
      cmd0(MODE_CONTINUOUS, 5'd2, 5'd4);
      seen3 = 0;
      prev_dbg = dbg_addr0;
      for (int i = 0; i < 100 && seen3 < 2; i++) begin
         @(negedge clk);
         if (dbg_addr0 == 5'd3 && prev_dbg != 5'd3) seen3++;
         prev_dbg = dbg_addr0;
      end
      check("cont_reached_second_pass", 64'(seen3), 64'd2);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      wait_done0("cont", 50);

      // Reset while a beat is being presented
      out_ready = 1'b0;
      cmd0(MODE_SWEEP, 5'd6, 5'd31);
      k = 0;
      while (!valid0 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("rst_reached_present", 64'(valid0), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs("mid_reset");
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("post_reset_idle", 64'(busy0), 64'd0);

      check("q0_drained", 64'(q0.size()), 64'd0);
      check("q3_drained", 64'(q3.size()), 64'd0);
      check("dq0_drained", 64'(dq0.size()), 64'd0);
      check("dq3_drained", 64'(dq3.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
